// File: rtl/reg_pair_sequencer.sv
// GB80 16-bit register-pair LOAD/INC/DEC sequencer.
// Reads the pair, then writes it back bytewise (BC/DE/HL/AF) or as one word (PC/SP).
module reg_pair_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [1:0]              i_op,
    input  logic [ADDR_WIDTH-1:0]   i_pair,
    input  logic [DATA_WIDTH*2-1:0] i_imm,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err,
    output logic [ADDR_WIDTH-1:0]   o_rf_addr_addr,
    output logic                    o_rf_addr_rd_en,
    input  logic [DATA_WIDTH*2-1:0] i_rf_addr_data,
    output logic                    o_rf_reg_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_rf_reg_wr_addr,
    output logic [DATA_WIDTH-1:0]   o_rf_reg_data,
    output logic [DATA_WIDTH*2-1:0] o_rf_addr_data,
    output logic                    o_rf_pc_wr_en,
    output logic                    o_rf_sp_wr_en,
    output logic                    o_rf_flags_wr_en,
    output logic [3:0]              o_rf_flags
);

    localparam int PW = DATA_WIDTH * 2;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_RSV  = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] P_BAD0 = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] P_PC   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] P_BAD2 = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] P_SP   = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] P_BC   = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] P_DE   = ADDR_WIDTH'(5);
    localparam logic [ADDR_WIDTH-1:0] P_HL   = ADDR_WIDTH'(6);
    localparam logic [ADDR_WIDTH-1:0] P_AF   = ADDR_WIDTH'(7);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WR16,
        S_WR_HI,
        S_WR_LO,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] pair_q, pair_d;
    logic [PW-1:0]         imm_q, imm_d;
    logic [PW-1:0]         result_q, result_d;
    logic                  err_q, err_d;

    logic                  illegal;
    logic                  is_word;
    logic [ADDR_WIDTH-1:0] hi_addr;
    logic [ADDR_WIDTH-1:0] lo_addr;

    assign illegal = (i_op == OP_RSV) || (i_pair == P_BAD0) || (i_pair == P_BAD2);
    assign is_word = (pair_q == P_PC) || (pair_q == P_SP);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            pair_q   <= '0;
            imm_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            pair_q   <= pair_d;
            imm_q    <= imm_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        pair_d   = pair_q;
        imm_d    = imm_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    op_d    = i_op;
                    pair_d  = i_pair;
                    imm_d   = i_imm;
                    err_d   = illegal;
                    state_d = illegal ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (op_q == OP_LOAD) begin
                    result_d = imm_q;
                end else if (op_q == OP_INC) begin
                    result_d = i_rf_addr_data + PW'(1);
                end else begin
                    result_d = i_rf_addr_data - PW'(1);
                end
                state_d = is_word ? S_WR16 : S_WR_HI;
            end
            S_WR16:  state_d = S_DONE;
            S_WR_HI: state_d = (pair_q == P_AF) ? S_DONE : S_WR_LO;
            S_WR_LO: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A sits at code 7, so the high-byte address is not simply {pair,0}
    always_comb begin
        hi_addr = '0;
        lo_addr = '0;
        case (pair_q)
            P_BC: begin
                hi_addr = ADDR_WIDTH'(0);
                lo_addr = ADDR_WIDTH'(1);
            end
            P_DE: begin
                hi_addr = ADDR_WIDTH'(2);
                lo_addr = ADDR_WIDTH'(3);
            end
            P_HL: begin
                hi_addr = ADDR_WIDTH'(4);
                lo_addr = ADDR_WIDTH'(5);
            end
            P_AF: begin
                hi_addr = ADDR_WIDTH'(7);
            end
            default: begin
                hi_addr = '0;
                lo_addr = '0;
            end
        endcase
    end

    always_comb begin
        o_busy           = (state_q != S_IDLE);
        o_done           = 1'b0;
        o_err            = 1'b0;
        o_rf_addr_addr   = '0;
        o_rf_addr_rd_en  = 1'b0;
        o_rf_reg_wr_en   = 1'b0;
        o_rf_reg_wr_addr = '0;
        o_rf_reg_data    = '0;
        o_rf_addr_data   = '0;
        o_rf_pc_wr_en    = 1'b0;
        o_rf_sp_wr_en    = 1'b0;
        o_rf_flags_wr_en = 1'b0;
        o_rf_flags       = '0;
        case (state_q)
            S_READ: begin
                o_rf_addr_addr  = pair_q;
                o_rf_addr_rd_en = 1'b1;
            end
            S_WR16: begin
                o_rf_addr_data = result_q;
                o_rf_pc_wr_en  = (pair_q == P_PC);
                o_rf_sp_wr_en  = (pair_q == P_SP);
            end
            S_WR_HI: begin
                o_rf_reg_wr_en   = 1'b1;
                o_rf_reg_wr_addr = hi_addr;
                o_rf_reg_data    = result_q[PW-1:DATA_WIDTH];
                if (pair_q == P_AF) begin
                    o_rf_flags_wr_en = 1'b1;
                    o_rf_flags       = result_q[DATA_WIDTH-1 -: 4];
                end
            end
            S_WR_LO: begin
                o_rf_reg_wr_en   = 1'b1;
                o_rf_reg_wr_addr = lo_addr;
                o_rf_reg_data    = result_q[DATA_WIDTH-1:0];
            end
            S_DONE: begin
                o_done = 1'b1;
                o_err  = err_q;
            end
            default: begin
                o_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_pair_sequencer.sv
// Directed bench for reg_pair_sequencer with an expected-write scoreboard.
module tb_reg_pair_sequencer;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [1:0]  i_op;
    logic [2:0]  i_pair;
    logic [15:0] i_imm;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [2:0]  o_rf_addr_addr;
    logic        o_rf_addr_rd_en;
    logic [15:0] rd_val;
    logic        o_rf_reg_wr_en;
    logic [2:0]  o_rf_reg_wr_addr;
    logic [7:0]  o_rf_reg_data;
    logic [15:0] o_rf_addr_data;
    logic        o_rf_pc_wr_en;
    logic        o_rf_sp_wr_en;
    logic        o_rf_flags_wr_en;
    logic [3:0]  o_rf_flags;
    logic [63:0] outs;

    always #5 clk = ~clk;

    reg_pair_sequencer dut (
        .i_clk           (clk),
        .i_reset         (i_reset),
        .i_start         (i_start),
        .i_op            (i_op),
        .i_pair          (i_pair),
        .i_imm           (i_imm),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_err           (o_err),
        .o_rf_addr_addr  (o_rf_addr_addr),
        .o_rf_addr_rd_en (o_rf_addr_rd_en),
        .i_rf_addr_data  (rd_val),
        .o_rf_reg_wr_en  (o_rf_reg_wr_en),
        .o_rf_reg_wr_addr(o_rf_reg_wr_addr),
        .o_rf_reg_data   (o_rf_reg_data),
        .o_rf_addr_data  (o_rf_addr_data),
        .o_rf_pc_wr_en   (o_rf_pc_wr_en),
        .o_rf_sp_wr_en   (o_rf_sp_wr_en),
        .o_rf_flags_wr_en(o_rf_flags_wr_en),
        .o_rf_flags      (o_rf_flags)
    );

    assign outs = {22'd0, o_busy, o_done, o_err, o_rf_addr_addr,
                   o_rf_addr_rd_en, o_rf_reg_wr_en, o_rf_reg_wr_addr,
                   o_rf_reg_data, o_rf_addr_data, o_rf_pc_wr_en,
                   o_rf_sp_wr_en, o_rf_flags_wr_en, o_rf_flags};

    // kind: 0 byte register write, 1 PC write, 2 SP write
    typedef struct {
        int          kind;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        fl;
        logic [3:0]  flags;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input int kind, input logic [2:0] addr, input logic [15:0] data,
                          input logic fl, input logic [3:0] flags);
        wr_t e;
        e.kind  = kind;
        e.addr  = addr;
        e.data  = data;
        e.fl    = fl;
        e.flags = flags;
        exp_q.push_back(e);
    endtask

    task automatic check_write();
        wr_t e;
        int  k;
        k = o_rf_reg_wr_en ? 0 : (o_rf_pc_wr_en ? 1 : 2);
        if (exp_q.size() == 0) begin
            chk("unexpected_write", 64'(k + 1), 0);
        end else begin
            e = exp_q.pop_front();
            chk("wr_kind", 64'(k), 64'(e.kind));
            if (e.kind == 0) begin
                chk("wr_addr", o_rf_reg_wr_addr, e.addr);
                chk("wr_data", o_rf_reg_data, e.data[7:0]);
                chk("flags_en", o_rf_flags_wr_en, e.fl);
                chk("flags", o_rf_flags, e.flags);
            end else begin
                chk("wr16_data", o_rf_addr_data, e.data);
            end
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [2:0] pair,
                          input logic [15:0] imm, input logic [15:0] rd,
                          input int lat, input logic err, input bit hold);
        int reads;
        bit done;
        reads = 0;
        done  = 0;
        @(negedge clk);
        i_start = 1'b1;
        i_op    = op;
        i_pair  = pair;
        i_imm   = imm;
        rd_val  = rd;
        @(posedge clk);
        #1;
        if (!hold) i_start = 1'b0;
        for (int cyc = 1; cyc <= 8 && !done; cyc++) begin
            @(negedge clk);
            chk("wr_exclusive",
                64'($countones({o_rf_reg_wr_en, o_rf_pc_wr_en, o_rf_sp_wr_en}) <= 1), 1);
            if (o_rf_addr_rd_en) begin
                reads++;
                chk("rd_addr", o_rf_addr_addr, pair);
            end
            if (o_rf_reg_wr_en || o_rf_pc_wr_en || o_rf_sp_wr_en) check_write();
            if (o_done) begin
                done = 1;
                chk("latency", 64'(cyc), 64'(lat));
                chk("err", o_err, err);
                chk("busy_in_done", o_busy, 1);
                i_start = 1'b0;
            end
        end
        if (!done) chk("done_timeout", 0, 1);
        chk("read_count", 64'(reads), err ? 0 : 1);
        chk("sb_empty", 64'(exp_q.size()), 0);
        exp_q.delete();
        @(negedge clk);
        chk("idle_outs", outs, 0);
    endtask

    initial begin
        int dones;
        i_reset = 1'b1;
        i_start = 1'b0;
        i_op    = '0;
        i_pair  = '0;
        i_imm   = '0;
        rd_val  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", outs, 0);
        i_reset = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", outs, 0);

        push_w(0, 3'd0, 16'h0012, 0, 4'h0);
        push_w(0, 3'd1, 16'h0034, 0, 4'h0);
        run_op(2'b00, 3'b100, 16'h1234, 16'h5555, 4, 0, 0);

        push_w(0, 3'd4, 16'h0001, 0, 4'h0);
        push_w(0, 3'd5, 16'h0000, 0, 4'h0);
        run_op(2'b01, 3'b110, 16'h0000, 16'h00FF, 4, 0, 0);

        push_w(0, 3'd2, 16'h00FF, 0, 4'h0);
        push_w(0, 3'd3, 16'h00FF, 0, 4'h0);
        run_op(2'b10, 3'b101, 16'h0000, 16'h0000, 4, 0, 0);

        push_w(2, 3'd0, 16'h0000, 0, 4'h0);
        run_op(2'b01, 3'b011, 16'h0000, 16'hFFFF, 3, 0, 0);

        push_w(1, 3'd0, 16'hC000, 0, 4'h0);
        run_op(2'b00, 3'b001, 16'hC000, 16'h1111, 3, 0, 0);

        push_w(0, 3'd7, 16'h00A5, 1, 4'hF);
        run_op(2'b00, 3'b111, 16'hA5F3, 16'h0000, 3, 0, 0);

        run_op(2'b00, 3'b010, 16'h1234, 16'h0000, 1, 1, 0);
        run_op(2'b11, 3'b100, 16'h1234, 16'h0000, 1, 1, 0);
        run_op(2'b01, 3'b000, 16'h0000, 16'h0000, 1, 1, 0);

        push_w(0, 3'd0, 16'h000F, 0, 4'h0);
        push_w(0, 3'd1, 16'h00FF, 0, 4'h0);
        run_op(2'b10, 3'b100, 16'h0000, 16'h1000, 4, 0, 1);
        repeat (2) begin
            @(negedge clk);
            chk("no_second_op", outs, 0);
        end

        // Reset lands while the low byte is being written
        @(negedge clk);
        i_start = 1'b1;
        i_op    = 2'b00;
        i_pair  = 3'b100;
        i_imm   = 16'h1234;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        @(negedge clk);
        chk("rst_read", o_rf_addr_rd_en, 1);
        @(negedge clk);
        chk("rst_b_wr", {o_rf_reg_wr_en, o_rf_reg_wr_addr, o_rf_reg_data}, {1'b1, 3'd0, 8'h12});
        @(negedge clk);
        chk("rst_in_wr_lo", {o_rf_reg_wr_en, o_rf_reg_wr_addr}, {1'b1, 3'd1});
        i_reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs", outs, 0);
        i_reset = 1'b0;
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (o_done || o_busy) dones++;
        end
        chk("rst_no_done", 64'(dones), 0);

        push_w(0, 3'd4, 16'h00BE, 0, 4'h0);
        push_w(0, 3'd5, 16'h00EF, 0, 4'h0);
        run_op(2'b00, 3'b110, 16'hBEEF, 16'h0000, 4, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
